falafel_resp_router: RTL and testbench

FALAFEL_RESP_ROUTER -- requirements
Module: falafel_resp_router

---
 rtl/falafel_resp_router.sv | 99 +++++++++
 tb/tb_falafel_resp_router.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_resp_router.sv
// Response router: pops {id, data} entries from a first-word-fall-through FIFO and
// presents each on the response port selected by its id, with a valid/ready handshake.
module falafel_resp_router #(
    parameter int NUM_RESP_PORTS = 1,
    parameter int DATA_W         = 64,
    parameter int MSG_ID_SIZE    = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             fifo_empty_i,
    output logic                             fifo_read_o,
    input  logic [MSG_ID_SIZE+DATA_W-1:0]    fifo_dout_i,
    output logic [NUM_RESP_PORTS-1:0]        rsp_val_o,
    input  logic [NUM_RESP_PORTS-1:0]        rsp_rdy_i,
    output logic [NUM_RESP_PORTS*DATA_W-1:0] rsp_data_o,
    output logic [15:0]                      sent_cnt_o,
    output logic [15:0]                      drop_cnt_o,
    output logic                             err_o
);

    // Wide enough to hold both any id and the port count (up to 255) without truncation.
    localparam int CMP_W = (MSG_ID_SIZE > 9) ? MSG_ID_SIZE : 9;
    localparam logic [CMP_W-1:0] PORTS_W = CMP_W'(NUM_RESP_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state;

    logic [MSG_ID_SIZE-1:0]           pop_id;
    logic [DATA_W-1:0]                pop_data;
    logic [CMP_W-1:0]                 pop_id_w;
    logic                             id_ok;
    logic                             handshake;
    logic                             pop;
    logic [NUM_RESP_PORTS-1:0]        val_d;
    logic [NUM_RESP_PORTS*DATA_W-1:0] data_d;

    assign pop_id   = fifo_dout_i[MSG_ID_SIZE+DATA_W-1 -: MSG_ID_SIZE];
    assign pop_data = fifo_dout_i[DATA_W-1:0];
    assign pop_id_w = CMP_W'(pop_id);
    assign id_ok    = (pop_id_w < PORTS_W);

    // Only the selected lane is ever valid, so the handshake is a simple reduction.
    assign handshake = (state == SEND) && (|(rsp_val_o & rsp_rdy_i));

    // The FIFO is popped in the same cycle a response completes, keeping one per cycle.
    assign pop = rst_ni && !fifo_empty_i && ((state == IDLE) || handshake);
    assign fifo_read_o = pop;

    always_comb begin
        val_d  = '0;
        data_d = '0;
        for (int p = 0; p < NUM_RESP_PORTS; p++) begin
            if (pop_id_w == CMP_W'(p)) begin
                val_d[p]                  = 1'b1;
                data_d[p*DATA_W +: DATA_W] = pop_data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state      <= IDLE;
            rsp_val_o  <= '0;
            rsp_data_o <= '0;
            sent_cnt_o <= '0;
            drop_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (pop) begin
                if (id_ok) begin
                    state      <= SEND;
                    rsp_val_o  <= val_d;
                    rsp_data_o <= data_d;
                end else begin
                    state      <= IDLE;
                    rsp_val_o  <= '0;
                    rsp_data_o <= '0;
                    err_o      <= 1'b1;
                    if (drop_cnt_o != 16'hFFFF) begin
                        drop_cnt_o <= drop_cnt_o + 16'd1;
                    end
                end
            end else if (handshake) begin
                state      <= IDLE;
                rsp_val_o  <= '0;
                rsp_data_o <= '0;
            end

            if (handshake && (sent_cnt_o != 16'hFFFF)) begin
                sent_cnt_o <= sent_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_falafel_resp_router.sv
// Bench for falafel_resp_router: queue-based FIFO and delivery model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_falafel_resp_router;

    localparam int NP = 2;
    localparam int DW = 16;
    localparam int IW = 8;

    logic              clk;
    logic              rst_ni;
    logic              fifo_empty_i;
    logic              fifo_read_o;
    logic [IW+DW-1:0]  fifo_dout_i;
    logic [NP-1:0]     rsp_val_o;
    logic [NP-1:0]     rsp_rdy_i;
    logic [NP*DW-1:0]  rsp_data_o;
    logic [15:0]       sent_cnt_o;
    logic [15:0]       drop_cnt_o;
    logic              err_o;

    falafel_resp_router #(
        .NUM_RESP_PORTS(NP),
        .DATA_W        (DW),
        .MSG_ID_SIZE   (IW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .fifo_empty_i(fifo_empty_i),
        .fifo_read_o (fifo_read_o),
        .fifo_dout_i (fifo_dout_i),
        .rsp_val_o   (rsp_val_o),
        .rsp_rdy_i   (rsp_rdy_i),
        .rsp_data_o  (rsp_data_o),
        .sent_cnt_o  (sent_cnt_o),
        .drop_cnt_o  (drop_cnt_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [IW+DW-1:0] fifo_q[$];
    logic [IW+DW-1:0] exp_q[$];
    int               m_sent = 0;
    int               m_drop = 0;
    logic             m_err  = 1'b0;
    logic             pop_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty_i = (fifo_q.size() == 0);
        fifo_dout_i  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endtask

    task automatic push(input logic [IW-1:0] id, input logic [DW-1:0] data);
        fifo_q.push_back({id, data});
        refresh();
    endtask

    // Expected outputs follow from the pending-delivery queue; then the coming edge is applied.
    task automatic compare_cycle();
        logic [NP-1:0]    ev;
        logic [NP*DW-1:0] ed;
        logic             hs_exp;
        logic             epop;
        logic [IW+DW-1:0] ent;
        ev = '0;
        ed = '0;
        hs_exp = 1'b0;
        if (exp_q.size() > 0) begin
            ev = NP'(1) << exp_q[0][DW];
            ed = {{DW{1'b0}}, exp_q[0][DW-1:0]} << (DW * int'(exp_q[0][DW]));
            hs_exp = rsp_rdy_i[exp_q[0][DW]];
        end
        epop = rst_ni && (fifo_q.size() > 0) && ((exp_q.size() == 0) || hs_exp);
        check("rsp_val", 64'(rsp_val_o), 64'(ev));
        check("rsp_data", 64'(rsp_data_o), 64'(ed));
        check("fifo_read", 64'(fifo_read_o), 64'(epop));
        check("sent_cnt", 64'(sent_cnt_o), 64'(m_sent));
        check("drop_cnt", 64'(drop_cnt_o), 64'(m_drop));
        check("err", 64'(err_o), 64'(m_err));
        if (!rst_ni) begin
            exp_q.delete();
            m_sent = 0;
            m_drop = 0;
            m_err  = 1'b0;
            pop_seen = 1'b0;
        end else begin
            if (hs_exp) begin
                exp_q.delete(0);
                if (m_sent < 65535) m_sent++;
            end
            pop_seen = (fifo_read_o === 1'b1);
            if (pop_seen && fifo_q.size() > 0) begin
                ent = fifo_q[0];
                if (ent[DW +: IW] < IW'(NP)) begin
                    exp_q.push_back(ent);
                end else begin
                    if (m_drop < 65535) m_drop++;
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
        if (pop_seen && fifo_q.size() > 0) fifo_q.delete(0);
        refresh();
    endtask

    task automatic push_random_valid();
        push(IW'($urandom_range(0, 1)), DW'($urandom_range(0, 65535)));
    endtask

    initial begin
        rst_ni    = 1'b0;
        rsp_rdy_i = '0;
        refresh();
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check("reset_val", 64'(rsp_val_o), 64'd0);
        check("reset_data", 64'(rsp_data_o), 64'd0);
        check("reset_sent", 64'(sent_cnt_o), 64'd0);
        check("reset_drop", 64'(drop_cnt_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        rst_ni = 1'b1;

        // Single valid response on port 1.
        rsp_rdy_i = 2'b11;
        push(8'd1, 16'hABCD);
        cycle();
        check("single_val", 64'(rsp_val_o), 64'h2);
        check("single_data", 64'(rsp_data_o[31:16]), 64'hABCD);
        cycle();
        check("single_sent", 64'(sent_cnt_o), 64'd1);
        check("single_idle", 64'(rsp_val_o), 64'd0);

        // Backpressure on port 1 for five cycles; port 0 ready must not matter.
        rsp_rdy_i = 2'b01;
        push(8'd1, 16'h1234);
        push(8'd0, 16'h5678);
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("bp_val", 64'(rsp_val_o), 64'h2);
            check("bp_data", 64'(rsp_data_o), 64'h1234_0000);
            check("bp_read", 64'(fifo_read_o), 64'd0);
            check("bp_sent", 64'(sent_cnt_o), 64'd1);
            cycle();
        end
        rsp_rdy_i = 2'b11;
        cycle();
        check("bp_next_val", 64'(rsp_val_o), 64'h1);
        check("bp_next_data", 64'(rsp_data_o), 64'h0000_5678);
        check("bp_sent_after", 64'(sent_cnt_o), 64'd2);
        cycle();
        check("bp_sent_done", 64'(sent_cnt_o), 64'd3);

        // Streaming: 8 entries, alternating ids, one handshake per cycle.
        for (int k = 0; k < 8; k++) begin
            fifo_q.push_back({IW'(k % 2), DW'(16'h0100 + k)});
        end
        refresh();
        cycle();
        for (int k = 0; k < 8; k++) begin
            check("stream_val", 64'(rsp_val_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            check("stream_hs", 64'(|(rsp_val_o & rsp_rdy_i)), 64'd1);
            cycle();
        end
        check("stream_sent", 64'(sent_cnt_o), 64'd11);
        check("stream_idle", 64'(rsp_val_o), 64'd0);

        // Invalid id is dropped; the following valid entry still goes out.
        push(8'd5, 16'hDEAD);
        push(8'd0, 16'hBEEF);
        cycle();
        check("inv_val", 64'(rsp_val_o), 64'd0);
        check("inv_drop", 64'(drop_cnt_o), 64'd1);
        check("inv_err", 64'(err_o), 64'd1);
        cycle();
        check("inv_next_val", 64'(rsp_val_o), 64'h1);
        check("inv_next_data", 64'(rsp_data_o), 64'h0000_BEEF);
        cycle();
        check("inv_sent", 64'(sent_cnt_o), 64'd12);

        // Random traffic: mixed ids including invalid ones, random readiness.
        for (int n = 0; n < 400; n++) begin
            int r;
            rsp_rdy_i = NP'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0 && fifo_q.size() < 4) begin
                r = $urandom_range(0, 9);
                if (r < 4)      push(8'd0, DW'($urandom_range(0, 65535)));
                else if (r < 8) push(8'd1, DW'($urandom_range(0, 65535)));
                else            push(IW'($urandom_range(2, 255)), DW'($urandom_range(0, 65535)));
            end
            cycle();
        end
        rsp_rdy_i = 2'b11;
        for (int n = 0; n < 30 && (fifo_q.size() > 0 || exp_q.size() > 0); n++) cycle();
        check("drain", 64'(fifo_q.size() + exp_q.size()), 64'd0);

        // Reset while a response is held; it must not reappear afterwards.
        rsp_rdy_i = 2'b00;
        push(8'd0, 16'h7777);
        push(8'd1, 16'h8888);
        cycle();
        check("mid_val", 64'(rsp_val_o), 64'h1);
        rst_ni = 1'b0;
        cycle();
        check("rst_val", 64'(rsp_val_o), 64'd0);
        check("rst_data", 64'(rsp_data_o), 64'd0);
        check("rst_read", 64'(fifo_read_o), 64'd0);
        check("rst_sent", 64'(sent_cnt_o), 64'd0);
        check("rst_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        rst_ni = 1'b1;
        rsp_rdy_i = 2'b11;
        cycle();
        check("post_rst_val", 64'(rsp_val_o), 64'h2);
        check("post_rst_data", 64'(rsp_data_o), 64'h8888_0000);
        cycle();
        check("post_rst_sent", 64'(sent_cnt_o), 64'd1);

        // Saturation of the delivered counter.
        for (int n = 0; n < 70000 && m_sent < 65535; n++) begin
            if (fifo_q.size() < 2) push_random_valid();
            cycle();
        end
        check("sat_reached", 64'(m_sent), 64'd65535);
        for (int n = 0; n < 10; n++) begin
            if (fifo_q.size() < 2) push_random_valid();
            cycle();
        end
        check("sat_sent", 64'(sent_cnt_o), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
